// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: op-code constants, op-code enum and legality helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_alu_pkg;

  localparam logic [3:0] CTRL_ADD  = 4'd0;
  localparam logic [3:0] CTRL_SUB  = 4'd1;
  localparam logic [3:0] CTRL_AND  = 4'd2;
  localparam logic [3:0] CTRL_OR   = 4'd3;
  localparam logic [3:0] CTRL_XOR  = 4'd4;
  localparam logic [3:0] CTRL_SLL  = 4'd5;
  localparam logic [3:0] CTRL_SRL  = 4'd6;
  localparam logic [3:0] CTRL_SRA  = 4'd7;
  localparam logic [3:0] CTRL_SLT  = 4'd8;
  localparam logic [3:0] CTRL_SLTU = 4'd9;

  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [3:0] {
    ALU_ADD  = CTRL_ADD,
    ALU_SUB  = CTRL_SUB,
    ALU_AND  = CTRL_AND,
    ALU_OR   = CTRL_OR,
    ALU_XOR  = CTRL_XOR,
    ALU_SLL  = CTRL_SLL,
    ALU_SRL  = CTRL_SRL,
    ALU_SRA  = CTRL_SRA,
    ALU_SLT  = CTRL_SLT,
    ALU_SLTU = CTRL_SLTU
  } alu_op_t;

  // Codes above the last defined op have no meaning; the ALU yields zero for them.
  function automatic logic alu_op_illegal(input logic [3:0] ctrl);
    return ctrl > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU: arithmetic, logic, shifts and set-less-than.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
module cpu_alu
  import cpu_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      i_control,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_less_than,
  output logic            o_unsigned_less_than
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  logic           w_lt;
  logic           w_ult;

  assign w_shamt = i_operand_b[SHW-1:0];
  assign w_lt    = $signed(i_operand_a) < $signed(i_operand_b);
  assign w_ult   = i_operand_a < i_operand_b;

  // Operation select; undefined codes fall through to a zero result.
  always_comb begin
    o_result = '0;
    case (i_control)
      CTRL_ADD:  o_result = i_operand_a + i_operand_b;
      CTRL_SUB:  o_result = i_operand_a - i_operand_b;
      CTRL_AND:  o_result = i_operand_a & i_operand_b;
      CTRL_OR:   o_result = i_operand_a | i_operand_b;
      CTRL_XOR:  o_result = i_operand_a ^ i_operand_b;
      CTRL_SLL:  o_result = i_operand_a << w_shamt;
      CTRL_SRL:  o_result = i_operand_a >> w_shamt;
      CTRL_SRA:  o_result = $signed(i_operand_a) >>> w_shamt;
      CTRL_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
      CTRL_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ult};
      default:   o_result = '0;
    endcase
  end

  assign o_zero               = (o_result == '0);
  assign o_less_than          = w_lt;
  assign o_unsigned_less_than = w_ult;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with optional grant lock; reusable for any shared unit.
// Latency: grant is combinational from i_req; priority pointer updates on i_accept.
// Backpressure: i_enable low forces an all-zero grant.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_enable,
  input  logic             i_lock,
  input  logic [IDX_W-1:0] i_lock_id,
  input  logic             i_accept,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  // r_ptr is the index with highest priority, i.e. one past the last grant.
  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  int               w_pos;

  // Pick the first requester at or after r_ptr (with wrap), or only the lock holder.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    if (i_enable) begin
      if (i_lock) begin
        for (int j = 0; j < N; j++) begin
          if ((i_lock_id == IDX_W'(j)) && i_req[j]) begin
            w_grant[j] = 1'b1;
            w_idx      = IDX_W'(j);
          end
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          w_pos = int'(r_ptr) + k;
          if (w_pos >= N) begin
            w_pos = w_pos - N;
          end
          for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j == w_pos)) begin
              w_found    = 1'b1;
              w_grant[j] = 1'b1;
              w_idx      = IDX_W'(j);
            end
          end
        end
      end
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

  // Advance priority past the winner whenever its request is actually taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_alu_arbiter.sv
// Shares one cpu_alu among NUM_REQ requesters; round-robin grant, tagged registered response.
// Latency: accept at edge N -> response valid after edge N; 1 op/cycle while rsp_ready=1.
// Backpressure: req_ready drops to zero while a held response sees rsp_ready=0.
// Optional build macro CPU_ALU_ARB_LOCK_EN: req_lock pins the grant to one requester.
module cpu_alu_arbiter
  import cpu_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*4-1:0]    req_control,
  input  logic [NUM_REQ*XLEN-1:0] req_operand_a,
  input  logic [NUM_REQ*XLEN-1:0] req_operand_b,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero,
  output logic                    rsp_less_than,
  output logic                    rsp_unsigned_less_than,
  output logic                    rsp_illegal
);

  // Output register: r_full marks a response waiting for the consumer.
  logic            r_full;
  logic [ID_W-1:0] r_id;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_lt;
  logic            r_ult;
  logic            r_illegal;

  logic               w_can_accept;
  logic               w_enable;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_accept;
  logic               w_lock_act;
  logic [ID_W-1:0]    w_lock_id;
  logic [3:0]         w_ctrl;
  logic [XLEN-1:0]    w_a;
  logic [XLEN-1:0]    w_b;
  logic [XLEN-1:0]    w_alu_result;
  logic               w_alu_zero;
  logic               w_alu_lt;
  logic               w_alu_ult;
  logic               w_illegal;

  // Room exists when empty, or when the held response leaves on this same edge.
  assign w_can_accept = !r_full || rsp_ready;
  assign w_enable     = reset_n && w_can_accept;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (req_valid),
    .i_enable    (w_enable),
    .i_lock      (w_lock_act),
    .i_lock_id   (w_lock_id),
    .i_accept    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  assign req_ready = w_grant;
  assign w_accept  = |(req_valid & w_grant);

`ifdef CPU_ALU_ARB_LOCK_EN
  logic            r_locked;
  logic [ID_W-1:0] r_lock_id;
  logic            w_sel_lock;

  assign w_sel_lock = |(req_lock & w_grant);
  assign w_lock_act = r_locked;
  assign w_lock_id  = r_lock_id;

  // While locked only the holder can be granted, so any accept comes from it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_locked  <= 1'b0;
      r_lock_id <= '0;
    end else if (w_accept) begin
      if (w_sel_lock) begin
        r_locked  <= 1'b1;
        r_lock_id <= w_gidx;
      end else begin
        r_locked  <= 1'b0;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;
  assign w_lock_act    = 1'b0;
  assign w_lock_id     = '0;
`endif

  // Steer the granted requester's control and operands into the shared ALU.
  always_comb begin
    w_ctrl = '0;
    w_a    = '0;
    w_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_ctrl = req_control[i*4 +: 4];
        w_a    = req_operand_a[i*XLEN +: XLEN];
        w_b    = req_operand_b[i*XLEN +: XLEN];
      end
    end
  end

  cpu_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_control            (w_ctrl),
    .i_operand_a          (w_a),
    .i_operand_b          (w_b),
    .o_result             (w_alu_result),
    .o_zero               (w_alu_zero),
    .o_less_than          (w_alu_lt),
    .o_unsigned_less_than (w_alu_ult)
  );

  assign w_illegal = alu_op_illegal(w_ctrl);

  // Capture on accept; otherwise a consumed response empties the register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_full    <= 1'b0;
      r_id      <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_lt      <= 1'b0;
      r_ult     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_full    <= 1'b1;
      r_id      <= w_gidx;
      r_result  <= w_illegal ? '0 : w_alu_result;
      r_zero    <= w_illegal ? 1'b1 : w_alu_zero;
      r_lt      <= w_alu_lt;
      r_ult     <= w_alu_ult;
      r_illegal <= w_illegal;
    end else if (rsp_ready) begin
      r_full    <= 1'b0;
    end
  end

  assign rsp_valid              = r_full;
  assign rsp_id                 = r_id;
  assign rsp_result             = r_result;
  assign rsp_zero               = r_zero;
  assign rsp_less_than          = r_lt;
  assign rsp_unsigned_less_than = r_ult;
  assign rsp_illegal            = r_illegal;

endmodule
